// File: rtl/codma_seq_pkg.sv
// Shared types and constants for the codma task sequencer: FSM state
// encoding, task types, status words and the two-word descriptor layout.
package codma_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PTR_CHK   = 4'd1,
        S_RD0       = 4'd2,
        S_WAIT0     = 4'd3,
        S_RD1       = 4'd4,
        S_WAIT1     = 4'd5,
        S_VALIDATE  = 4'd6,
        S_ISSUE     = 4'd7,
        S_WAIT_DONE = 4'd8,
        S_LINK      = 4'd9,
        S_STATUS    = 4'd10
    } seq_state_e;

    localparam logic [31:0] TASK_SINGLE = 32'd0;
    localparam logic [31:0] TASK_BURST  = 32'd1;
    localparam logic [31:0] TASK_LINK   = 32'd2;

    localparam logic [63:0] STATUS_OK  = 64'd0;
    localparam logic [63:0] STATUS_ERR = 64'd1;

    localparam logic [31:0] LINK_STRIDE = 32'd32;
    localparam logic [31:0] DESC_BYTES  = 32'd16;

    // word0 = {src, type}, word1 = {len, dst}
    typedef struct packed {
        logic [31:0] src;
        logic [31:0] task_type;
        logic [31:0] len;
        logic [31:0] dst;
    } desc_t;

    function automatic desc_t desc_unpack(input logic [63:0] word0, input logic [63:0] word1);
        desc_t d;
        d.src       = word0[63:32];
        d.task_type = word0[31:0];
        d.len       = word1[63:32];
        d.dst       = word1[31:0];
        return d;
    endfunction

endpackage

// File: rtl/codma_desc_check.sv
// Combinational descriptor validator: task type, length granularity and
// source/destination bounds. Sums are 33 bits wide so they cannot wrap.
module codma_desc_check
    import codma_seq_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  desc_t i_desc,
    output logic  o_ok
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    logic        w_type_bad;
    logic        w_len_zero;
    logic        w_len_misaligned;
    logic        w_src_oob;
    logic        w_dst_oob;
    logic [32:0] w_src_end;
    logic [32:0] w_dst_end;

    assign w_src_end = {1'b0, i_desc.src} + {1'b0, i_desc.len};
    assign w_dst_end = {1'b0, i_desc.dst} + {1'b0, i_desc.len};

    // Evaluate each rejection rule; single beats need 8-byte lengths, bursts 32-byte.
    always_comb begin
        w_type_bad = (i_desc.task_type > TASK_LINK);
        w_len_zero = (i_desc.len == 32'd0);
        if (i_desc.task_type == TASK_SINGLE) begin
            w_len_misaligned = (i_desc.len[2:0] != 3'd0);
        end else begin
            w_len_misaligned = (i_desc.len[4:0] != 5'd0);
        end
        w_src_oob = (w_src_end > MEM_LIMIT);
        w_dst_oob = (w_dst_end > MEM_LIMIT);
        o_ok = !(w_type_bad || w_len_zero || w_len_misaligned || w_src_oob || w_dst_oob);
    end

endmodule

// File: rtl/codma_task_sequencer.sv
// codma task sequencer: fetches and validates descriptors, issues copy
// commands, follows linked chains and writes back a status word.
// Optional build macro CODMA_SEQ_TIMEOUT_EN adds a copy-engine watchdog.
module codma_task_sequencer
    import codma_seq_pkg::*;
#(
    parameter int MEM_DEPTH      = 32,
    parameter int MEM_WIDTH      = 8,
    parameter int MAX_LINKS      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [31:0] task_pointer_i,
    input  logic [31:0] status_pointer_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i,
    output logic        cmd_valid_o,
    output logic [31:0] cmd_src_o,
    output logic [31:0] cmd_dst_o,
    output logic [31:0] cmd_len_o,
    output logic        cmd_burst_o,
    input  logic        cmd_ready_i,
    input  logic        cmd_done_i,
    input  logic        cmd_err_i
);

    localparam int          MEM_BYTES = MEM_DEPTH * MEM_WIDTH;
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
    localparam int          LW        = $clog2(MAX_LINKS + 1);

    seq_state_e    r_state;
    seq_state_e    w_next_state;
    logic [31:0]   r_cur_ptr;
    logic [31:0]   r_status_ptr;
    logic [63:0]   r_word0;
    logic [63:0]   r_word1;
    logic [LW-1:0] r_link_cnt;
    logic [LW-1:0] w_link_inc;
    logic          r_err;
    logic          w_err_set;
    logic          w_err_final;
    logic [32:0]   w_ptr_end;
    desc_t         w_desc;
    logic          w_desc_ok;

    logic          r_busy;
    logic          r_done;
    logic          r_err_out;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [63:0]   r_mem_wdata;
    logic          r_cmd_valid;
    logic [31:0]   r_cmd_src;
    logic [31:0]   r_cmd_dst;
    logic [31:0]   r_cmd_len;
    logic          r_cmd_burst;

`ifdef CODMA_SEQ_TIMEOUT_EN
    logic [31:0]   r_to_cnt;
`endif

    assign w_desc      = desc_unpack(r_word0, r_word1);
    assign w_ptr_end   = {1'b0, r_cur_ptr} + {1'b0, DESC_BYTES};
    assign w_link_inc  = r_link_cnt + LW'(1);
    assign w_err_final = r_err | w_err_set;

    codma_desc_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_desc_check (
        .i_desc (w_desc),
        .o_ok   (w_desc_ok)
    );

    // Next-state logic; w_err_set flags every transition that ends the task in error.
    always_comb begin
        w_next_state = r_state;
        w_err_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_next_state = S_PTR_CHK;
                else         w_next_state = S_IDLE;
            end
            S_PTR_CHK: begin
                if (w_ptr_end > MEM_LIMIT) begin
                    w_err_set    = 1'b1;
                    w_next_state = S_STATUS;
                end else begin
                    w_next_state = S_RD0;
                end
            end
            S_RD0: begin
                if (mem_gnt_i) w_next_state = S_WAIT0;
                else           w_next_state = S_RD0;
            end
            S_WAIT0: begin
                if (mem_rvalid_i) w_next_state = S_RD1;
                else              w_next_state = S_WAIT0;
            end
            S_RD1: begin
                if (mem_gnt_i) w_next_state = S_WAIT1;
                else           w_next_state = S_RD1;
            end
            S_WAIT1: begin
                if (mem_rvalid_i) w_next_state = S_VALIDATE;
                else              w_next_state = S_WAIT1;
            end
            S_VALIDATE: begin
                if (!w_desc_ok) begin
                    w_err_set    = 1'b1;
                    w_next_state = S_STATUS;
                end else begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready_i) w_next_state = S_WAIT_DONE;
                else             w_next_state = S_ISSUE;
            end
            S_WAIT_DONE: begin
                if (cmd_done_i) begin
                    if (cmd_err_i) begin
                        w_err_set    = 1'b1;
                        w_next_state = S_STATUS;
                    end else if (w_desc.task_type == TASK_LINK) begin
                        w_next_state = S_LINK;
                    end else begin
                        w_next_state = S_STATUS;
                    end
                end
`ifdef CODMA_SEQ_TIMEOUT_EN
                else if (r_to_cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
                    w_err_set    = 1'b1;
                    w_next_state = S_STATUS;
                end
`endif
                else begin
                    w_next_state = S_WAIT_DONE;
                end
            end
            S_LINK: begin
                if (w_link_inc == LW'(MAX_LINKS)) begin
                    w_err_set    = 1'b1;
                    w_next_state = S_STATUS;
                end else begin
                    w_next_state = S_PTR_CHK;
                end
            end
            S_STATUS: begin
                if (mem_gnt_i) w_next_state = S_IDLE;
                else           w_next_state = S_STATUS;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // Task context: pointers, link counter, sticky error and fetched descriptor words.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cur_ptr    <= 32'd0;
            r_status_ptr <= 32'd0;
            r_link_cnt   <= '0;
            r_err        <= 1'b0;
            r_word0      <= 64'd0;
            r_word1      <= 64'd0;
        end else begin
            if (r_state == S_IDLE && start_i) begin
                r_cur_ptr    <= task_pointer_i;
                r_status_ptr <= status_pointer_i;
                r_link_cnt   <= '0;
                r_err        <= 1'b0;
            end else if (r_state == S_LINK) begin
                r_link_cnt <= w_link_inc;
                r_cur_ptr  <= r_cur_ptr + LINK_STRIDE;
                r_err      <= w_err_final;
            end else begin
                r_err <= w_err_final;
            end
            if (r_state == S_WAIT0 && mem_rvalid_i) r_word0 <= mem_rdata_i;
            if (r_state == S_WAIT1 && mem_rvalid_i) r_word1 <= mem_rdata_i;
        end
    end

`ifdef CODMA_SEQ_TIMEOUT_EN
    // Watchdog: counts cycles spent in WAIT_DONE, cleared whenever outside it.
    always_ff @(posedge clk_i) begin
        if (reset_i)                     r_to_cnt <= 32'd0;
        else if (r_state != S_WAIT_DONE) r_to_cnt <= 32'd0;
        else                             r_to_cnt <= r_to_cnt + 32'd1;
    end
`endif

    // Output registers, decoded from the next state so they align with the state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_out   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 64'd0;
            r_cmd_valid <= 1'b0;
            r_cmd_src   <= 32'd0;
            r_cmd_dst   <= 32'd0;
            r_cmd_len   <= 32'd0;
            r_cmd_burst <= 1'b0;
        end else begin
            r_busy      <= (w_next_state != S_IDLE);
            r_done      <= (r_state == S_STATUS) && mem_gnt_i;
            r_err_out   <= (r_state == S_STATUS) && mem_gnt_i && r_err;
            r_mem_req   <= (w_next_state == S_RD0) || (w_next_state == S_RD1) ||
                           (w_next_state == S_STATUS);
            r_mem_we    <= (w_next_state == S_STATUS);
            r_cmd_valid <= (w_next_state == S_ISSUE);
            case (w_next_state)
                S_RD0:    r_mem_addr <= r_cur_ptr;
                S_RD1:    r_mem_addr <= r_cur_ptr + 32'd8;
                S_STATUS: r_mem_addr <= r_status_ptr;
                default:  r_mem_addr <= 32'd0;
            endcase
            if (w_next_state == S_STATUS) r_mem_wdata <= w_err_final ? STATUS_ERR : STATUS_OK;
            else                          r_mem_wdata <= 64'd0;
            if (r_state == S_VALIDATE && w_next_state == S_ISSUE) begin
                r_cmd_src   <= w_desc.src;
                r_cmd_dst   <= w_desc.dst;
                r_cmd_len   <= w_desc.len;
                r_cmd_burst <= (w_desc.task_type != TASK_SINGLE);
            end
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err_out;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign cmd_valid_o = r_cmd_valid;
    assign cmd_src_o   = r_cmd_src;
    assign cmd_dst_o   = r_cmd_dst;
    assign cmd_len_o   = r_cmd_len;
    assign cmd_burst_o = r_cmd_burst;

endmodule

// File: tb/tb_codma_task_sequencer.sv
// Scoreboard bench for codma_task_sequencer: a queue-based reference model
// predicts reads, copy commands and status writes; a monitor checks them.
module tb_codma_task_sequencer;

`ifdef CODMA_SEQ_TIMEOUT_EN
    localparam int TB_TIMEOUT_CYCLES = 16;
`else
    localparam int TB_TIMEOUT_CYCLES = 1024;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] task_pointer_i = 32'd0;
    logic [31:0] status_pointer_i = 32'd0;
    logic        busy_o, done_o, err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = 64'd0;
    logic        cmd_valid_o;
    logic [31:0] cmd_src_o, cmd_dst_o, cmd_len_o;
    logic        cmd_burst_o;
    logic        cmd_ready_i = 1'b0;
    logic        cmd_done_i = 1'b0;
    logic        cmd_err_i = 1'b0;

    always #5 clk_i = ~clk_i;

    codma_task_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT_CYCLES)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .task_pointer_i(task_pointer_i), .status_pointer_i(status_pointer_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .cmd_valid_o(cmd_valid_o), .cmd_src_o(cmd_src_o),
        .cmd_dst_o(cmd_dst_o), .cmd_len_o(cmd_len_o), .cmd_burst_o(cmd_burst_o),
        .cmd_ready_i(cmd_ready_i), .cmd_done_i(cmd_done_i), .cmd_err_i(cmd_err_i)
    );

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        logic        burst;
    } cmd_t;

    logic [63:0] mem [0:31];
    logic [31:0] q_rd_addr [$];
    cmd_t        q_cmd [$];
    logic [31:0] q_st_addr [$];
    logic [63:0] q_st_data [$];
    logic        q_done_err [$];
    bit          q_cerr_plan [$];
    bit          hang = 1'b0;
    bit          cmd_hs_seen = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic put_desc(input int p, input logic [31:0] ty, input logic [31:0] src,
                            input logic [31:0] dst, input logic [31:0] len);
        mem[p / 8]     = {src, ty};
        mem[p / 8 + 1] = {len, dst};
    endtask

    // Reference model: walks the chain with plain arithmetic and queues the
    // reads, commands and the single status write the sequencer must produce.
    task automatic model_run(input logic [31:0] tptr, input logic [31:0] sptr, input bit errs[$]);
        longint unsigned ptr, ty, src, dst, len;
        int   links = 0;
        int   k = 0;
        bit   err = 1'b0;
        cmd_t c;
        ptr = longint'(tptr);
        while (1) begin
            if (ptr + 16 > 256) begin err = 1'b1; break; end
            q_rd_addr.push_back(32'(ptr));
            q_rd_addr.push_back(32'(ptr + 8));
            ty  = longint'(mem[ptr / 8][31:0]);
            src = longint'(mem[ptr / 8][63:32]);
            dst = longint'(mem[ptr / 8 + 1][31:0]);
            len = longint'(mem[ptr / 8 + 1][63:32]);
            if (ty > 2 || len == 0 || (ty == 0 && len % 8 != 0) || (ty != 0 && len % 32 != 0) ||
                src + len > 256 || dst + len > 256) begin
                err = 1'b1; break;
            end
            c.src = 32'(src); c.dst = 32'(dst); c.len = 32'(len); c.burst = (ty != 0);
            q_cmd.push_back(c);
            if (k < errs.size() && errs[k]) begin err = 1'b1; break; end
            k++;
            if (ty != 2) break;
            links++;
            if (links == 8) begin err = 1'b1; break; end
            ptr = ptr + 32;
        end
        q_st_addr.push_back(sptr);
        q_st_data.push_back(err ? 64'd1 : 64'd0);
        q_done_err.push_back(err);
    endtask

    task automatic flush_queues();
        q_rd_addr.delete(); q_cmd.delete(); q_st_addr.delete();
        q_st_data.delete(); q_done_err.delete();
    endtask

    task automatic check_drained(input string name);
        check({name, "_reads_left"}, q_rd_addr.size(), 0);
        check({name, "_cmds_left"}, q_cmd.size(), 0);
        check({name, "_status_left"}, q_st_addr.size(), 0);
    endtask

    task automatic run_test(input string name, input logic [31:0] tptr, input logic [31:0] sptr,
                            input bit errs[$], input bit poke_start);
        bit done_seen = 1'b0;
        q_cerr_plan = errs;
        model_run(tptr, sptr, errs);
        @(negedge clk_i);
        task_pointer_i = tptr; status_pointer_i = sptr; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check({name, "_busy_after_start"}, busy_o, 1);
        for (int c = 0; c < 3000; c++) begin
            if (done_o) begin done_seen = 1'b1; break; end
            start_i = (poke_start && busy_o && $urandom_range(0, 3) == 0);
            @(negedge clk_i);
        end
        start_i = 1'b0;
        check({name, "_done_seen"}, done_seen, 1);
        check({name, "_busy_at_done"}, busy_o, 0);
        if (!done_seen) begin
            reset_i = 1'b1; @(negedge clk_i); reset_i = 1'b0;
            flush_queues();
        end
        @(negedge clk_i);
        check({name, "_done_one_cycle"}, done_o, 0);
        repeat (2) @(negedge clk_i);
        check_drained(name);
    endtask

    // Memory responder: random grant delay, read data 1-3 cycles after grant.
    initial begin
        bit          last_hs = 1'b0, last_we = 1'b0, pend = 1'b0;
        logic [31:0] last_addr = 32'd0, paddr = 32'd0;
        int          dly = 0;
        forever begin
            @(posedge clk_i); #1;
            mem_rvalid_i = 1'b0;
            if (reset_i) begin
                mem_gnt_i = 1'b0; last_hs = 1'b0; pend = 1'b0;
            end else begin
                if (last_hs && !last_we) begin
                    pend = 1'b1; paddr = last_addr; dly = $urandom_range(0, 2);
                end
                if (pend) begin
                    if (dly == 0) begin
                        mem_rvalid_i = 1'b1; mem_rdata_i = mem[paddr[7:3]]; pend = 1'b0;
                    end else begin
                        dly--;
                    end
                end
                mem_gnt_i = mem_req_o && !pend && ($urandom_range(0, 2) != 0);
                last_hs = mem_gnt_i; last_we = mem_we_o; last_addr = mem_addr_o;
            end
        end
    end

    // Copy-engine responder: random ready, done 1-5 cycles after accept, error from plan.
    initial begin
        bit last_c = 1'b0, cbusy = 1'b0, cerr = 1'b0;
        int cdly = 0;
        forever begin
            @(posedge clk_i); #1;
            cmd_done_i = 1'b0; cmd_err_i = 1'b0;
            if (reset_i) begin
                cmd_ready_i = 1'b0; last_c = 1'b0; cbusy = 1'b0;
            end else begin
                if (last_c) begin
                    cmd_hs_seen = 1'b1;
                    cerr = (q_cerr_plan.size() != 0) ? q_cerr_plan.pop_front() : 1'b0;
                    if (!hang) begin cbusy = 1'b1; cdly = $urandom_range(0, 4); end
                end
                if (cbusy) begin
                    if (cdly == 0) begin cmd_done_i = 1'b1; cmd_err_i = cerr; cbusy = 1'b0; end
                    else cdly--;
                end
                cmd_ready_i = cmd_valid_o && !cbusy && ($urandom_range(0, 1) == 1);
                last_c = cmd_ready_i;
            end
        end
    end

    // Monitor: inputs and outputs are stable at the falling edge; pop and compare.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!reset_i) begin
                if (mem_req_o && mem_gnt_i) begin
                    check("mem_addr_align", mem_addr_o[2:0], 0);
                    if (mem_we_o) begin
                        check("status_write_expected", q_st_addr.size() != 0, 1);
                        if (q_st_addr.size() != 0) begin
                            check("status_addr", mem_addr_o, q_st_addr.pop_front());
                            check("status_data", mem_wdata_o, q_st_data.pop_front());
                        end
                    end else begin
                        check("read_expected", q_rd_addr.size() != 0, 1);
                        if (q_rd_addr.size() != 0) check("read_addr", mem_addr_o, q_rd_addr.pop_front());
                    end
                end
                if (cmd_valid_o && cmd_ready_i) begin
                    check("cmd_expected", q_cmd.size() != 0, 1);
                    if (q_cmd.size() != 0) begin
                        cmd_t e;
                        e = q_cmd.pop_front();
                        check("cmd_src", cmd_src_o, e.src);
                        check("cmd_dst", cmd_dst_o, e.dst);
                        check("cmd_len", cmd_len_o, e.len);
                        check("cmd_burst", cmd_burst_o, e.burst);
                    end
                end
                if (done_o) begin
                    check("done_expected", q_done_err.size() != 0, 1);
                    if (q_done_err.size() != 0) check("err_o", err_o, q_done_err.pop_front());
                end
            end
        end
    end

    task automatic gen_random(output logic [31:0] tptr, output logic [31:0] sptr, output bit errs[$]);
        int nd, p, r;
        logic [31:0] ty, len;
        errs = {};
        for (int i = 0; i < 32; i++) mem[i] = {$urandom(), $urandom()};
        nd   = $urandom_range(1, 3);
        tptr = ($urandom_range(0, 9) == 0) ? 32'(8 * $urandom_range(28, 40)) : 32'(8 * $urandom_range(0, 27));
        for (int k = 0; k < nd; k++) begin
            p = int'(tptr) + 32 * k;
            if (p + 16 <= 256) begin
                ty = (k < nd - 1) ? 32'd2 : 32'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) ty = 32'($urandom_range(0, 4));
                len = (ty == 32'd0) ? 32'(8 * $urandom_range(1, 4)) : 32'(32 * $urandom_range(1, 2));
                r = $urandom_range(0, 9);
                if (r == 0) len = 32'd0;
                else if (r == 1) len = len + 32'd4;
                put_desc(p, ty, 32'(8 * $urandom_range(0, 27)), 32'(8 * $urandom_range(0, 27)), len);
            end
            errs.push_back($urandom_range(0, 7) == 0);
        end
        sptr = 32'(8 * $urandom_range(0, 31));
    endtask

    initial begin
        logic [31:0] tp, sp;
        bit          errs [$];
        bit          no_err [$];
        bit          hs_ok;
        no_err = {};
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_mem_req", mem_req_o, 0);
        check("reset_cmd_valid", cmd_valid_o, 0);
        check("reset_addr_wdata", {mem_addr_o, mem_wdata_o[31:0]}, 0);

        // Single task
        for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        put_desc(32'h40, 32'd0, 32'h00, 32'h80, 32'd16);
        run_test("single", 32'h40, 32'hC0, no_err, 1'b0);

        // Burst task
        for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        put_desc(32'h00, 32'd1, 32'h20, 32'hA0, 32'd64);
        run_test("burst", 32'h00, 32'hF8, no_err, 1'b0);

        // Linked pair
        for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        put_desc(32'h20, 32'd2, 32'h00, 32'h80, 32'd32);
        put_desc(32'h40, 32'd0, 32'h08, 32'hC0, 32'd8);
        run_test("linked", 32'h20, 32'h10, no_err, 1'b0);

        // Source out of bounds
        for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        put_desc(32'h40, 32'd1, 32'hF0, 32'h00, 32'd32);
        run_test("src_oob", 32'h40, 32'h00, no_err, 1'b0);

        // Descriptor pointer beyond memory
        run_test("ptr_oob", 32'hF8, 32'h08, no_err, 1'b0);

        // Chain hitting the link limit
        for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        for (int k = 0; k < 8; k++) put_desc(32 * k, 32'd2, 32'h00, 32'h80, 32'd32);
        run_test("max_links", 32'h00, 32'h18, no_err, 1'b0);

        // start_i pulsed while busy must be ignored
        for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        put_desc(32'h40, 32'd0, 32'h00, 32'h80, 32'd16);
        run_test("start_while_busy", 32'h40, 32'hC0, no_err, 1'b1);

        // Reset while waiting for copy completion
        hang = 1'b1; cmd_hs_seen = 1'b0; q_cerr_plan = {};
        model_run(32'h40, 32'hC0, no_err);
        void'(q_st_addr.pop_back()); void'(q_st_data.pop_back()); void'(q_done_err.pop_back());
        @(negedge clk_i);
        task_pointer_i = 32'h40; status_pointer_i = 32'hC0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        hs_ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (cmd_hs_seen) begin hs_ok = 1'b1; break; end
            @(negedge clk_i);
        end
        check("rst_cmd_accepted", hs_ok, 1);
        repeat (3) @(negedge clk_i);
        check("rst_busy_before", busy_o, 1);
        reset_i = 1'b1;
        @(negedge clk_i);
        check("rst_busy_after", busy_o, 0);
        check("rst_req_after", mem_req_o, 0);
        reset_i = 1'b0; hang = 1'b0;
        repeat (10) @(negedge clk_i);
        check("rst_no_done", done_o, 0);
        check_drained("rst");
        run_test("after_reset", 32'h40, 32'hC0, no_err, 1'b0);

`ifdef CODMA_SEQ_TIMEOUT_EN
        // Copy engine never completes: watchdog must end the task in error
        hang = 1'b1;
        errs = {};
        errs.push_back(1'b1);
        run_test("timeout", 32'h40, 32'hC0, errs, 1'b0);
        hang = 1'b0;
`endif

        for (int t = 0; t < 40; t++) begin
            gen_random(tp, sp, errs);
            run_test("random", tp, sp, errs, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
